// File: rtl/prime_check.sv
// -----------------------------------------------------------------------------
// prime_check
//
// Responder-side primality tester on a go/ready handshake. A candidate is
// accepted while the block is idle, then tested by sequential trial division:
// for each trial divisor d (2, 3, 4, ...) a restoring shift-subtract remainder
// unit walks the candidate MSB first, one bit per cycle. The search stops at
// the first divisor that leaves no remainder (composite) or as soon as d*d
// exceeds the candidate (prime). d*d is tracked incrementally in sq, so no
// multiplier is needed: (d+1)^2 = d^2 + 2d + 1.
//
// Parameters
//   WIDTH_LOG  log2 of the operand width; W = 1 << WIDTH_LOG (W >= 4)
//
// Ports
//   clk       in   1   single clock, all state on posedge
//   rst       in   1   asynchronous, active-high reset
//   go        in   1   start request, honoured only while ready = 1
//   num       in   W   candidate, captured on an accepted go
//   ready     out  1   1 = idle and results valid, 0 = busy
//   is_prime  out  1   1 = captured candidate is prime
//   divisor   out  W   smallest divisor >= 2 (candidate if prime, 0 if < 2)
//   error     out  1   1 = go was seen while busy since the last accept
// -----------------------------------------------------------------------------
module prime_check #(
    parameter int WIDTH_LOG = 4,
    localparam int W = 1 << WIDTH_LOG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] num,
    output logic         ready,
    output logic         is_prime,
    output logic [W-1:0] divisor,
    output logic         error
);

    // Trial divisor never exceeds 2^(W/2), so W/2+1 bits are enough.
    localparam int DW = W / 2 + 1;
    // Square of the trial divisor reaches 2^W, with one bit of headroom.
    localparam int SW = W + 2;
    // Shifted partial remainder is one bit wider than the remainder.
    localparam int TW = W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TEST = 2'd1;
    localparam logic [1:0] S_REM  = 2'd2;

    localparam logic [DW-1:0]        TRIAL_FIRST = DW'(2);
    localparam logic [SW-1:0]        SQ_FIRST    = SW'(4);
    localparam logic [W-1:0]         N_TWO       = W'(2);
    localparam logic [W-1:0]         W_ZERO      = W'(0);
    localparam logic [WIDTH_LOG-1:0] BIT_MSB     = WIDTH_LOG'(W - 1);
    localparam logic [WIDTH_LOG-1:0] BIT_ZERO    = WIDTH_LOG'(0);
    localparam logic [WIDTH_LOG-1:0] BIT_ONE     = WIDTH_LOG'(1);
    localparam logic [DW-1:0]        TRIAL_ONE   = DW'(1);

    // Architectural state
    logic [1:0]           state_q,    state_d;
    logic [W-1:0]         n_q,        n_d;
    logic [DW-1:0]        trial_q,    trial_d;
    logic [SW-1:0]        sq_q,       sq_d;
    logic [W-1:0]         rem_q,      rem_d;
    logic [WIDTH_LOG-1:0] bit_q,      bit_d;
    logic                 ready_q,    ready_d;
    logic                 is_prime_q, is_prime_d;
    logic [W-1:0]         divisor_q,  divisor_d;
    logic                 error_q,    error_d;

    // Remainder datapath
    logic [TW-1:0] shift_s;
    logic          take_s;
    logic [W-1:0]  rem_step_s;
    logic          accept_s;

    // One restoring division step: bring in the next candidate bit and
    // subtract the trial divisor when it fits. Because the running remainder
    // is always below d, the difference fits in W bits, so the subtraction
    // is done at W bits while the compare uses the full W+1 bits.
    always_comb begin
        shift_s    = {rem_q, n_q[bit_q]};
        take_s     = (shift_s >= TW'(trial_q));
        if (take_s) begin
            rem_step_s = shift_s[W-1:0] - W'(trial_q);
        end else begin
            rem_step_s = shift_s[W-1:0];
        end
    end

    assign accept_s = ready_q & go;

    // Next-state logic for the IDLE -> TEST -> REM -> (TEST | IDLE) sequencer.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        trial_d    = trial_q;
        sq_d       = sq_q;
        rem_d      = rem_q;
        bit_d      = bit_q;
        ready_d    = ready_q;
        is_prime_d = is_prime_q;
        divisor_d  = divisor_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    n_d        = num;
                    trial_d    = TRIAL_FIRST;
                    sq_d       = SQ_FIRST;
                    rem_d      = W_ZERO;
                    bit_d      = BIT_ZERO;
                    ready_d    = 1'b0;
                    is_prime_d = 1'b0;
                    divisor_d  = W_ZERO;
                    state_d    = S_TEST;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            S_TEST: begin
                if (n_q < N_TWO) begin
                    // 0 and 1 are neither prime nor have a divisor >= 2.
                    is_prime_d = 1'b0;
                    divisor_d  = W_ZERO;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                end else if (sq_q > SW'(n_q)) begin
                    // No divisor up to sqrt(n) found: n is prime. This also
                    // catches n = 2 and n = 3 before any division runs.
                    is_prime_d = 1'b1;
                    divisor_d  = n_q;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    rem_d      = W_ZERO;
                    bit_d      = BIT_MSB;
                    state_d    = S_REM;
                end
            end

            S_REM: begin
                rem_d = rem_step_s;
                bit_d = bit_q - BIT_ONE;
                if (bit_q == BIT_ZERO) begin
                    if (rem_step_s == W_ZERO) begin
                        is_prime_d = 1'b0;
                        divisor_d  = W'(trial_q);
                        ready_d    = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        // Advance to the next trial divisor and its square.
                        sq_d       = sq_q + SW'({trial_q, 1'b1});
                        trial_d    = trial_q + TRIAL_ONE;
                        state_d    = S_TEST;
                    end
                end else begin
                    state_d    = S_REM;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe idle state.
                ready_d    = 1'b1;
                is_prime_d = 1'b0;
                divisor_d  = W_ZERO;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Busy-time go requests are flagged and only cleared by the next accept.
    always_comb begin
        if (accept_s) begin
            error_d = 1'b0;
        end else if (!ready_q && go) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= W_ZERO;
            trial_q    <= '0;
            sq_q       <= '0;
            rem_q      <= W_ZERO;
            bit_q      <= BIT_ZERO;
            ready_q    <= 1'b1;
            is_prime_q <= 1'b0;
            divisor_q  <= W_ZERO;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            trial_q    <= trial_d;
            sq_q       <= sq_d;
            rem_q      <= rem_d;
            bit_q      <= bit_d;
            ready_q    <= ready_d;
            is_prime_q <= is_prime_d;
            divisor_q  <= divisor_d;
            error_q    <= error_d;
        end
    end

    assign ready    = ready_q;
    assign is_prime = is_prime_q;
    assign divisor  = divisor_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prime_check.sv
// -----------------------------------------------------------------------------
// tb_prime_check
//
// Directed bench for prime_check (W = 16). A transaction-level model computes
// the smallest divisor and the busy time of each accepted candidate with plain
// arithmetic; a negedge process compares every DUT output against it on every
// cycle. Directed launches additionally pin results and latencies to
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_prime_check;

    localparam int WL  = 4;
    localparam int W   = 16;
    localparam int STEP = W + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go  = 1'b0;
    logic [W-1:0]  num = '0;
    logic          ready;
    logic          is_prime;
    logic [W-1:0]  divisor;
    logic          error;

    int n_vec = 0;
    int n_bad = 0;

    prime_check #(.WIDTH_LOG(WL)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .num      (num),
        .ready    (ready),
        .is_prime (is_prime),
        .divisor  (divisor),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Smallest divisor >= 2 by plain trial division; 0 for n < 2.
    function automatic int unsigned ref_div(input int unsigned n);
        if (n < 2) return 0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            if (n % d == 0) return d;
        end
        return n;
    endfunction

    // Cycles with ready low: k divisors tried cost W+1 cycles each, and a
    // prime needs one extra closing test.
    function automatic int unsigned ref_lat(input int unsigned n);
        int unsigned k;
        if (n < 4) return 1;
        k = 0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            k++;
            if (n % d == 0) return k * STEP;
        end
        return k * STEP + 1;
    endfunction

    // Transaction model of the responder.
    logic         m_ready;
    logic         m_prime;
    logic [W-1:0] m_div;
    logic         m_err;
    logic [W-1:0] m_num;
    int unsigned  m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_prime <= 1'b0;
            m_div   <= '0;
            m_err   <= 1'b0;
            m_num   <= '0;
            m_cnt   <= 0;
        end else if (m_ready) begin
            if (go) begin
                m_ready <= 1'b0;
                m_prime <= 1'b0;
                m_div   <= '0;
                m_err   <= 1'b0;
                m_num   <= num;
                m_cnt   <= ref_lat(num);
            end
        end else begin
            if (go) m_err <= 1'b1;
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_div   <= W'(ref_div(m_num));
                m_prime <= (m_num >= 2) && (ref_div(m_num) == m_num);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        chk("mdl_ready",    ready,    m_ready);
        chk("mdl_is_prime", is_prime, m_prime);
        chk("mdl_divisor",  divisor,  m_div);
        chk("mdl_error",    error,    m_err);
    end

    // Launch one candidate, wait for completion, check against literals.
    task automatic launch(input logic [W-1:0] v, input logic ep, input logic [W-1:0] ed, input int el);
        int cnt;
        num = v;
        go  = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        cnt = 0;
        while (!ready && cnt < 5000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk($sformatf("latency n=%0d", v),  cnt,      el);
        chk($sformatf("is_prime n=%0d", v), is_prime, ep);
        chk($sformatf("divisor n=%0d", v),  divisor,  ed);
    endtask

    int unsigned div_tab [19] = '{2, 3, 2, 5, 2, 7, 2, 3, 2, 11, 2, 13, 2, 3, 2, 17, 2, 19, 2};

    initial begin
        int cnt;
        int unsigned exp_d;

        // Power-up reset
        #1 rst = 1'b1;
        #11;
        chk("rst_ready",    ready,    1);
        chk("rst_is_prime", is_prime, 0);
        chk("rst_divisor",  divisor,  0);
        chk("rst_error",    error,    0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Small and trivial candidates
        launch(16'd0, 1'b0, 16'd0, 1);
        launch(16'd1, 1'b0, 16'd0, 1);
        launch(16'd2, 1'b1, 16'd2, 1);
        launch(16'd3, 1'b1, 16'd3, 1);

        // Composites and primes, including the operand-width extremes
        launch(16'd4,     1'b0, 16'd2,     17);
        launch(16'd91,    1'b0, 16'd7,     102);
        launch(16'd97,    1'b1, 16'd97,    137);
        launch(16'd65535, 1'b0, 16'd3,     34);
        launch(16'd65521, 1'b1, 16'd65521, 4319);

        // go pulse while busy: flagged, computation undisturbed
        num = 16'd97;
        go  = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        num = 16'd10;
        cnt = 0;
        while (!ready && cnt < 5000) begin
            go = (cnt == 5);
            @(posedge clk); #1;
            cnt++;
        end
        go = 1'b0;
        chk("busy_go latency",  cnt,      137);
        chk("busy_go is_prime", is_prime, 1);
        chk("busy_go divisor",  divisor,  97);
        chk("busy_go error",    error,    1);
        launch(16'd5, 1'b1, 16'd5, 18);
        chk("error cleared", error, 0);

        // Reset in the middle of a remainder pass
        num = 16'd97;
        go  = 1'b1;
        @(posedge clk); #1;
        go  = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready",    ready,    1);
        chk("midrst_is_prime", is_prime, 0);
        chk("midrst_divisor",  divisor,  0);
        chk("midrst_error",    error,    0);
        @(posedge clk); #1;
        rst = 1'b0;
        launch(16'd5, 1'b1, 16'd5, 18);

        // go held high: back-to-back launches over 2..20
        go = 1'b1;
        for (int v = 2; v <= 20; v++) begin
            num = W'(v);
            @(posedge clk); #1;
            chk($sformatf("sweep accept n=%0d", v), ready, 0);
            cnt = 0;
            while (!ready && cnt < 500) begin
                @(posedge clk); #1;
                cnt++;
            end
            exp_d = div_tab[v - 2];
            chk($sformatf("sweep done n=%0d", v),     ready,    1);
            chk($sformatf("sweep divisor n=%0d", v),  divisor,  exp_d);
            chk($sformatf("sweep is_prime n=%0d", v), is_prime, (exp_d == v) ? 1 : 0);
        end
        go = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
